bfly_stage_ctrl: RTL and testbench
==================================

BFLY_STAGE_CTRL -- requirements
Module: bfly_stage_ctrl

Interface
REQ-001 SHALL have parameter NUM, default 16, meaning parallel lanes per beat.
REQ-002 SHALL have parameter DATA, default 512, meaning FFT points per frame.
REQ-003 SHALL have derived parameters COUNT = DATA/NUM (default 32), meaning beats per frame, and H = COUNT/2, meaning half-frame beats and delay-FIFO depth.
REQ-004 SHALL have port clk, input, 1, meaning clock (rising edge).
REQ-005 SHALL have port rstn, input, 1, meaning reset: asynchronous, active-low.
REQ-006 SHALL have port valid_in, input, 1, meaning one NUM-lane beat accepted this cycle; input is never backpressured.
REQ-007 SHALL have port flush, input, 1, meaning synchronous abort of the current frame.
REQ-008 SHALL have ports sr_write, sr_read and sr_clr, outputs, 1 each, meaning delay-FIFO push, pop and clear.
REQ-009 SHALL have ports bfly_en and out_sel, outputs, 1 each; bfly_en means butterfly computing, out_sel means 0 = sum path, 1 = difference popped from FIFO.
REQ-010 SHALL have ports valid_out, frame_done and busy, outputs, 1 each.

Function
REQ-011 SHALL implement FSM states IDLE, FILL, CALC and DRAIN, with fill_cnt, calc_cnt and drn_cnt each $clog2(H)+1 bits wide.
REQ-012 SHALL decode all control outputs combinationally from state, counters and valid_in (zero latency); the butterfly datapath is combinational.
REQ-013 In IDLE, on valid_in: SHALL assert sr_write, set fill_cnt=1 and go to FILL.
REQ-014 In FILL, on each valid_in: SHALL assert sr_write and increment fill_cnt; the beat making fill_cnt reach H SHALL move the FSM to CALC and clear fill_cnt.
REQ-015 In CALC, on each valid_in: SHALL assert sr_read, sr_write (difference pushed back), bfly_en and valid_out, with out_sel=0; the H-th CALC beat SHALL move the FSM to DRAIN.
REQ-016 In DRAIN, every cycle regardless of valid_in: SHALL assert sr_read and valid_out with out_sel=1, and increment drn_cnt.
REQ-017 In DRAIN, valid_in SHALL be next-frame first-half data: assert sr_write and increment fill_cnt; at most H such beats are possible.
REQ-018 On the H-th DRAIN cycle, SHALL pulse frame_done, then go to IDLE if fill_cnt=0, CALC (fill_cnt cleared) if fill_cnt=H, else FILL with fill_cnt kept.
REQ-019 In FILL and CALC, cycles without valid_in SHALL hold all counters and the state, and assert no strobes.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 flush SHALL have priority over everything: all strobes except sr_clr low that cycle, sr_clr pulsed for one cycle, next state IDLE, counters zeroed; a valid_in in the same cycle is dropped.

Reset
REQ-022 While rstn=0, SHALL set state=IDLE and all counters to 0, and drive every output 0 (sr_clr 0, busy 0).
REQ-023 Reset asserted mid-frame SHALL discard the frame; the first valid_in after release SHALL start a new FILL.

Configuration
REQ-024 With BFLY_STAGE_CTRL_TWIDDLE_EN defined, SHALL add output tw_addr [$clog2(H)-1:0], equal to drn_cnt during DRAIN (0..H-1) and 0 otherwise, reset 0, cleared by flush.
REQ-025 Without BFLY_STAGE_CTRL_TWIDDLE_EN, SHALL omit the tw_addr port and its logic; all other behaviour is identical.

Verification
REQ-026 SHALL cover a single frame of 32 contiguous beats from cycle 0 -> sr_write only on cycles 0-15; valid_out with out_sel=0 and bfly_en on cycles 16-31; out_sel=1 on cycles 32-47; frame_done on cycle 47; busy=0 on cycle 48.
REQ-027 SHALL cover 64 contiguous beats -> valid_out continuous on cycles 16-79; second frame enters CALC on cycle 48 with no IDLE; frame_done on cycles 47 and 79.
REQ-028 SHALL cover valid_in on alternate cycles -> counters hold on idle cycles; CALC entered after the 16th beat; bfly_en only on valid cycles; DRAIN still 16 consecutive cycles.
REQ-029 SHALL cover 5 beats during DRAIN -> FILL entered with fill_cnt=5; CALC entered after 11 more beats.
REQ-030 SHALL cover flush on the 4th CALC beat -> sr_clr=1 for one cycle, next cycle state IDLE with all outputs 0; the next valid_in starts a FILL.
REQ-031 SHALL cover, with BFLY_STAGE_CTRL_TWIDDLE_EN defined, a single frame -> tw_addr 0..15 on DRAIN cycles 32-47 and 0 elsewhere.

Source files
------------

// File: rtl/bfly_stage_ctrl_if.sv
// Control bus of one radix-2 butterfly stage: beat input, FIFO strobes, output qualifiers.
// tw_addr exists only when BFLY_STAGE_CTRL_TWIDDLE_EN is defined.
interface bfly_stage_ctrl_if #(
  parameter int NUM  = 16,
  parameter int DATA = 512
) ();
  localparam int COUNT = DATA / NUM;
  localparam int H     = COUNT / 2;
  localparam int TW_W  = $clog2(H);

  // Handshake: valid_in marks one NUM-lane beat accepted in the cycle it is high.
  // There is no ready; the stage never backpressures. valid_out likewise marks
  // one output beat in the cycle it is high, with out_sel choosing the path.
  logic valid_in;
  logic flush;
  logic sr_write;
  logic sr_read;
  logic sr_clr;
  logic bfly_en;
  logic out_sel;
  logic valid_out;
  logic frame_done;
  logic busy;
`ifdef BFLY_STAGE_CTRL_TWIDDLE_EN
  logic [TW_W-1:0] tw_addr;
`endif

  modport master (
    output valid_in, flush,
    input  sr_write, sr_read, sr_clr, bfly_en, out_sel, valid_out, frame_done, busy
`ifdef BFLY_STAGE_CTRL_TWIDDLE_EN
    , input tw_addr
`endif
  );

  modport slave (
    input  valid_in, flush,
    output sr_write, sr_read, sr_clr, bfly_en, out_sel, valid_out, frame_done, busy
`ifdef BFLY_STAGE_CTRL_TWIDDLE_EN
    , output tw_addr
`endif
  );
endinterface

// File: rtl/bfly_stage_ctrl.sv
// Sequencer for a delay-feedback butterfly stage: FILL stores the first half-frame,
// CALC emits sums, DRAIN emits the stored differences. Optional BFLY_STAGE_CTRL_TWIDDLE_EN adds tw_addr.
module bfly_stage_ctrl #(
  parameter int NUM  = 16,
  parameter int DATA = 512
) (
  input  logic                        clk,
  input  logic                        rstn,
  bfly_stage_ctrl_if.slave            bus,
  output logic [1:0]                  o_dbg_state,
  output logic [$clog2((DATA/NUM)/2):0] o_dbg_fill_cnt
);
  localparam int COUNT = DATA / NUM;
  localparam int H     = COUNT / 2;
  localparam int CW    = $clog2(H) + 1;
  localparam logic [CW-1:0] H_C = CW'(H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CALC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_fill_cnt;
  logic [CW-1:0] r_calc_cnt;
  logic [CW-1:0] r_drn_cnt;

  state_t        w_state_nxt;
  logic [CW-1:0] w_fill_nxt;
  logic [CW-1:0] w_calc_nxt;
  logic [CW-1:0] w_drn_nxt;
  logic [CW-1:0] w_fill_inc;
  logic [CW-1:0] w_calc_inc;
  logic [CW-1:0] w_drn_inc;

  logic w_sr_write;
  logic w_sr_read;
  logic w_sr_clr;
  logic w_bfly_en;
  logic w_out_sel;
  logic w_valid_out;
  logic w_frame_done;

  assign w_fill_inc = r_fill_cnt + 1'b1;
  assign w_calc_inc = r_calc_cnt + 1'b1;
  assign w_drn_inc  = r_drn_cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_fill_cnt <= '0;
      r_calc_cnt <= '0;
      r_drn_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_calc_cnt <= w_calc_nxt;
      r_drn_cnt  <= w_drn_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fill_nxt   = r_fill_cnt;
    w_calc_nxt   = r_calc_cnt;
    w_drn_nxt    = r_drn_cnt;
    w_sr_write   = 1'b0;
    w_sr_read    = 1'b0;
    w_sr_clr     = 1'b0;
    w_bfly_en    = 1'b0;
    w_out_sel    = 1'b0;
    w_valid_out  = 1'b0;
    w_frame_done = 1'b0;

    if (bus.flush) begin
      // Abort wins over any beat arriving in the same cycle.
      w_sr_clr    = 1'b1;
      w_state_nxt = S_IDLE;
      w_fill_nxt  = '0;
      w_calc_nxt  = '0;
      w_drn_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_FILL: begin
          if (bus.valid_in) begin
            w_sr_write = 1'b1;
            if (w_fill_inc == H_C) begin
              w_state_nxt = S_CALC;
              w_fill_nxt  = '0;
            end else begin
              w_state_nxt = S_FILL;
              w_fill_nxt  = w_fill_inc;
            end
          end
        end

        S_CALC: begin
          if (bus.valid_in) begin
            w_sr_read   = 1'b1;
            w_sr_write  = 1'b1;
            w_bfly_en   = 1'b1;
            w_valid_out = 1'b1;
            if (w_calc_inc == H_C) begin
              w_state_nxt = S_DRAIN;
              w_calc_nxt  = '0;
              w_drn_nxt   = '0;
            end else begin
              w_calc_nxt = w_calc_inc;
            end
          end
        end

        S_DRAIN: begin
          w_sr_read   = 1'b1;
          w_valid_out = 1'b1;
          w_out_sel   = 1'b1;
          w_drn_nxt   = w_drn_inc;
          // Incoming beats are the next frame's first half, sharing the FIFO slots being popped.
          if (bus.valid_in && (r_fill_cnt != H_C)) begin
            w_sr_write = 1'b1;
            w_fill_nxt = w_fill_inc;
          end
          if (w_drn_inc == H_C) begin
            w_frame_done = 1'b1;
            w_drn_nxt    = '0;
            if (w_fill_nxt == '0) begin
              w_state_nxt = S_IDLE;
            end else if (w_fill_nxt == H_C) begin
              w_state_nxt = S_CALC;
              w_fill_nxt  = '0;
            end else begin
              w_state_nxt = S_FILL;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_fill_nxt  = '0;
          w_calc_nxt  = '0;
          w_drn_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode from valid_in directly, so they are forced low while reset is held.
  assign bus.sr_write   = rstn & w_sr_write;
  assign bus.sr_read    = rstn & w_sr_read;
  assign bus.sr_clr     = rstn & w_sr_clr;
  assign bus.bfly_en    = rstn & w_bfly_en;
  assign bus.out_sel    = rstn & w_out_sel;
  assign bus.valid_out  = rstn & w_valid_out;
  assign bus.frame_done = rstn & w_frame_done;
  assign bus.busy       = rstn & (r_state != S_IDLE);

`ifdef BFLY_STAGE_CTRL_TWIDDLE_EN
  localparam int TW = $clog2(H);
  assign bus.tw_addr = (rstn && !bus.flush && (r_state == S_DRAIN)) ? r_drn_cnt[TW-1:0] : '0;
`endif

  assign o_dbg_state    = r_state;
  assign o_dbg_fill_cnt = r_fill_cnt;
endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Directed bench for bfly_stage_ctrl (default NUM=16, DATA=512: H=16 beats per half-frame).
module tb_bfly_stage_ctrl;
  logic clk;
  logic rstn;
  logic [1:0] dbg_state;
  logic [4:0] dbg_fill;
  logic [7:0] obs;
  int n_checks;
  int n_pass;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Bit order: {sr_write, sr_read, sr_clr, bfly_en, out_sel, valid_out, frame_done, busy}
  localparam logic [7:0] E_NONE    = 8'b0000_0000;
  localparam logic [7:0] E_FILL0   = 8'b1000_0000;
  localparam logic [7:0] E_FILL    = 8'b1000_0001;
  localparam logic [7:0] E_HOLD    = 8'b0000_0001;
  localparam logic [7:0] E_CALC    = 8'b1101_0101;
  localparam logic [7:0] E_DRAIN   = 8'b0100_1101;
  localparam logic [7:0] E_DRAIN_W = 8'b1100_1101;
  localparam logic [7:0] E_FD      = 8'b0000_0010;
  localparam logic [7:0] E_CLR     = 8'b0010_0001;

  bfly_stage_ctrl_if bus ();

  bfly_stage_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus),
    .o_dbg_state    (dbg_state),
    .o_dbg_fill_cnt (dbg_fill)
  );

  assign obs = {bus.sr_write, bus.sr_read, bus.sr_clr, bus.bfly_en,
                bus.out_sel, bus.valid_out, bus.frame_done, bus.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc_begin(input logic vi, input logic fl);
    bus.valid_in = vi;
    bus.flush    = fl;
    @(negedge clk);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.valid_in = 1'b1;
    bus.flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== E_NONE) $display("FAIL reset_outputs got=%b exp=%b", obs, E_NONE);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE || dbg_fill !== 5'd0)
      $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_fill);
    else n_pass++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.valid_in = 1'b0;
    cyc_begin(1'b0, 1'b0);
    n_checks++;
    if (obs !== E_NONE) $display("FAIL reset_release got=%b exp=%b", obs, E_NONE);
    else n_pass++;
    cyc_end();
  endtask

  task automatic test_single_frame();
    logic [7:0] exp;
    for (int c = 0; c <= 48; c++) begin
      cyc_begin(c < 32, 1'b0);
      if (c == 0) exp = E_FILL0;
      else if (c < 16) exp = E_FILL;
      else if (c < 32) exp = E_CALC;
      else if (c < 48) exp = E_DRAIN | ((c == 47) ? E_FD : E_NONE);
      else exp = E_NONE;
      n_checks++;
      if (obs !== exp) $display("FAIL single_frame cyc=%0d got=%b exp=%b", c, obs, exp);
      else n_pass++;
`ifdef BFLY_STAGE_CTRL_TWIDDLE_EN
      n_checks++;
      if (bus.tw_addr !== ((c >= 32 && c < 48) ? 4'(c - 32) : 4'd0))
        $display("FAIL tw_addr cyc=%0d got=%0d", c, bus.tw_addr);
      else n_pass++;
`endif
      cyc_end();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int c = 0; c <= 80; c++) begin
      cyc_begin(c < 64, 1'b0);
      if (c == 0) exp = E_FILL0;
      else if (c < 16) exp = E_FILL;
      else if (c < 32) exp = E_CALC;
      else if (c < 48) exp = E_DRAIN_W | ((c == 47) ? E_FD : E_NONE);
      else if (c < 64) exp = E_CALC;
      else if (c < 80) exp = E_DRAIN | ((c == 79) ? E_FD : E_NONE);
      else exp = E_NONE;
      n_checks++;
      if (obs !== exp) $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs, exp);
      else n_pass++;
      if (c == 48) begin
        n_checks++;
        if (dbg_state !== ST_CALC) $display("FAIL b2b_no_idle got=%0d exp=%0d", dbg_state, ST_CALC);
        else n_pass++;
      end
      cyc_end();
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp;
    for (int c = 0; c <= 79; c++) begin
      cyc_begin((c % 2 == 0) && (c <= 62), 1'b0);
      if (c == 0) exp = E_FILL0;
      else if (c < 31) exp = (c % 2 == 0) ? E_FILL : E_HOLD;
      else if (c < 63) exp = (c % 2 == 0) ? E_CALC : E_HOLD;
      else if (c < 79) exp = E_DRAIN | ((c == 78) ? E_FD : E_NONE);
      else exp = E_NONE;
      n_checks++;
      if (obs !== exp) $display("FAIL alternate cyc=%0d got=%b exp=%b", c, obs, exp);
      else n_pass++;
      if (c % 2 == 1 && c < 31) begin
        n_checks++;
        if (dbg_fill !== 5'((c + 1) / 2) || dbg_state !== ST_FILL)
          $display("FAIL alt_hold cyc=%0d got=%0d/%0d exp=%0d/%0d", c, dbg_state, dbg_fill, ST_FILL, (c + 1) / 2);
        else n_pass++;
      end
      if (c == 31) begin
        n_checks++;
        if (dbg_state !== ST_CALC || dbg_fill !== 5'd0)
          $display("FAIL alt_calc_entry got=%0d/%0d exp=2/0", dbg_state, dbg_fill);
        else n_pass++;
      end
      cyc_end();
    end
  endtask

  task automatic test_drain_fill();
    logic [7:0] exp;
    for (int c = 0; c <= 91; c++) begin
      cyc_begin((c <= 36) || (c >= 48 && c <= 74), 1'b0);
      if (c == 0) exp = E_FILL0;
      else if (c < 16) exp = E_FILL;
      else if (c < 32) exp = E_CALC;
      else if (c < 37) exp = E_DRAIN_W;
      else if (c < 48) exp = E_DRAIN | ((c == 47) ? E_FD : E_NONE);
      else if (c < 59) exp = E_FILL;
      else if (c < 75) exp = E_CALC;
      else if (c < 91) exp = E_DRAIN | ((c == 90) ? E_FD : E_NONE);
      else exp = E_NONE;
      n_checks++;
      if (obs !== exp) $display("FAIL drain_fill cyc=%0d got=%b exp=%b", c, obs, exp);
      else n_pass++;
      if (c == 48 || c == 58 || c == 59) begin
        n_checks++;
        if (c == 48 && (dbg_state !== ST_FILL || dbg_fill !== 5'd5))
          $display("FAIL drain_fill_state cyc=%0d got=%0d/%0d exp=1/5", c, dbg_state, dbg_fill);
        else if (c == 58 && (dbg_state !== ST_FILL || dbg_fill !== 5'd15))
          $display("FAIL drain_fill_state cyc=%0d got=%0d/%0d exp=1/15", c, dbg_state, dbg_fill);
        else if (c == 59 && (dbg_state !== ST_CALC || dbg_fill !== 5'd0))
          $display("FAIL drain_fill_state cyc=%0d got=%0d/%0d exp=2/0", c, dbg_state, dbg_fill);
        else n_pass++;
      end
      cyc_end();
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp;
    for (int c = 0; c <= 18; c++) begin
      cyc_begin(1'b1, 1'b0);
      exp = (c == 0) ? E_FILL0 : ((c < 16) ? E_FILL : E_CALC);
      n_checks++;
      if (obs !== exp) $display("FAIL flush_pre cyc=%0d got=%b exp=%b", c, obs, exp);
      else n_pass++;
      cyc_end();
    end
    cyc_begin(1'b1, 1'b1);
    n_checks++;
    if (obs !== E_CLR) $display("FAIL flush_clr got=%b exp=%b", obs, E_CLR);
    else n_pass++;
    cyc_end();
    cyc_begin(1'b0, 1'b0);
    n_checks++;
    if (obs !== E_NONE || dbg_state !== ST_IDLE || dbg_fill !== 5'd0)
      $display("FAIL flush_idle got=%b/%0d/%0d exp=%b/0/0", obs, dbg_state, dbg_fill, E_NONE);
    else n_pass++;
    cyc_end();
    cyc_begin(1'b1, 1'b0);
    n_checks++;
    if (obs !== E_FILL0) $display("FAIL flush_restart got=%b exp=%b", obs, E_FILL0);
    else n_pass++;
    cyc_end();
    cyc_begin(1'b0, 1'b0);
    n_checks++;
    if (obs !== E_HOLD || dbg_state !== ST_FILL || dbg_fill !== 5'd1)
      $display("FAIL flush_refill got=%b/%0d/%0d exp=%b/1/1", obs, dbg_state, dbg_fill, E_HOLD);
    else n_pass++;
    cyc_end();
    cyc_begin(1'b0, 1'b1);
    cyc_end();
  endtask

  task automatic test_reset_midframe();
    for (int c = 0; c < 8; c++) begin
      cyc_begin(1'b1, 1'b0);
      cyc_end();
    end
    bus.valid_in = 1'b1;
    rstn = 1'b0;
    #2;
    n_checks++;
    if (obs !== E_NONE || dbg_state !== ST_IDLE || dbg_fill !== 5'd0)
      $display("FAIL midframe_reset got=%b/%0d/%0d exp=%b/0/0", obs, dbg_state, dbg_fill, E_NONE);
    else n_pass++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc_begin(1'b1, 1'b0);
    n_checks++;
    if (obs !== E_FILL0) $display("FAIL midframe_restart got=%b exp=%b", obs, E_FILL0);
    else n_pass++;
    cyc_end();
    cyc_begin(1'b0, 1'b0);
    n_checks++;
    if (dbg_state !== ST_FILL || dbg_fill !== 5'd1)
      $display("FAIL midframe_fill got=%0d/%0d exp=1/1", dbg_state, dbg_fill);
    else n_pass++;
    cyc_end();
    cyc_begin(1'b0, 1'b1);
    cyc_end();
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_alternate();
    test_drain_fill();
    test_flush();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
